// File: rtl/psum_merge_unit.sv
// psum_merge_unit
//   Output-stage merger between NUM_CH parallel PE result lanes, the partial-sum
//   input FIFO and the single-write output FIFO. Each step captures one PE result
//   vector. Depending on mode, the unit then adds incoming partial sums per lane,
//   reduces across the lanes, or does both. The results are serialised into the
//   output FIFO.
//
//   Modes: 0 pass, 1 lane+psum, 2 lane reduce, 3 reduce+psum.
//
//   Ports:
//     clk, rstn            clock, asynchronous active-low reset
//     start, clear         job start pulse (IDLE only) / synchronous abort
//     mode, vec_count      job configuration, latched at start
//     pe_data/valid/ready  PE result vector capture (lane i at [i*IN_W +: IN_W])
//     psum_data/empty/ren  show-ahead partial-sum FIFO read side
//     out_data/full/wen    output FIFO write side
//     busy, done           status; done pulses once after the last word
//     sat_flag             sticky clamp indicator (saturating build only)
//
//   Build option: define PSUM_MERGE_SATURATE_EN to clamp every add to the
//   signed ACC_W range and expose sat_flag. Otherwise arithmetic wraps.
module psum_merge_unit #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned IN_W   = 16,
  parameter int unsigned ACC_W  = 24,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     start,
  input  logic                     clear,
  input  logic [1:0]               mode,
  input  logic [CNT_W-1:0]         vec_count,
  input  logic [NUM_CH*IN_W-1:0]   pe_data,
  input  logic                     pe_valid,
  output logic                     pe_ready,
  input  logic [ACC_W-1:0]         psum_data,
  input  logic                     psum_empty,
  output logic                     psum_ren,
  output logic [ACC_W-1:0]         out_data,
  input  logic                     out_full,
  output logic                     out_wen,
  output logic                     busy,
  output logic                     done
`ifdef PSUM_MERGE_SATURATE_EN
  ,
  output logic                     sat_flag
`endif
);

  localparam int unsigned     CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CAPTURE, S_MERGE, S_FINAL, S_EMIT, S_DONE
  } state_e;

  typedef enum logic [1:0] {
    M_PASS, M_LANE_PSUM, M_REDUCE, M_REDUCE_PSUM
  } mode_e;

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [CNT_W-1:0] remain_q, remain_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic [ACC_W-1:0] lane_q [NUM_CH];
  logic [ACC_W-1:0] lane_d [NUM_CH];
  logic [ACC_W-1:0] acc_q, acc_d;

  logic [ACC_W-1:0] lane_sel;
  logic [ACC_W-1:0] add_a, add_b, add_res;

  assign lane_sel = lane_q[ch_q];

  // A single shared adder serves every merge step, because at most one add
  // happens per cycle: lane+psum, acc+lane, or acc+psum.
`ifdef PSUM_MERGE_SATURATE_EN
  logic [ACC_W:0] add_wide;
  logic           add_ovf;
  logic           sat_q, sat_d;

  always_comb begin
    add_wide = {add_a[ACC_W-1], add_a} + {add_b[ACC_W-1], add_b};
    add_ovf  = add_wide[ACC_W] ^ add_wide[ACC_W-1];
    if (!add_ovf) begin
      add_res = add_wide[ACC_W-1:0];
    end else if (add_wide[ACC_W]) begin
      add_res = {1'b1, {(ACC_W-1){1'b0}}};
    end else begin
      add_res = {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  // An add commits on every psum pop and on every reduce step in MERGE.
  always_comb begin
    sat_d = sat_q;
    if (state_q == S_IDLE && start && !clear) begin
      sat_d = 1'b0;
    end else if (add_ovf && (psum_ren || (state_q == S_MERGE && mode_q != M_LANE_PSUM))) begin
      sat_d = 1'b1;
    end
  end

  assign sat_flag = sat_q;
`else
  assign add_res = add_a + add_b;
`endif

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    remain_d = remain_q;
    ch_d     = ch_q;
    lane_d   = lane_q;
    acc_d    = acc_q;
    add_a    = acc_q;
    add_b    = lane_sel;
    psum_ren = 1'b0;
    out_wen  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (vec_count == '0) begin
            state_d = S_DONE;
          end else begin
            mode_d   = mode_e'(mode);
            remain_d = vec_count;
            state_d  = S_CAPTURE;
          end
        end
      end

      S_CAPTURE: begin
        if (pe_valid) begin
          for (int unsigned i = 0; i < NUM_CH; i++) begin
            lane_d[i] = ACC_W'($signed(pe_data[i*IN_W +: IN_W]));
          end
          acc_d   = '0;
          ch_d    = '0;
          state_d = (mode_q == M_PASS) ? S_EMIT : S_MERGE;
        end
      end

      S_MERGE: begin
        if (mode_q == M_LANE_PSUM) begin
          add_a = lane_sel;
          add_b = psum_data;
          if (!psum_empty) begin
            psum_ren     = 1'b1;
            lane_d[ch_q] = add_res;
            if (ch_q == LAST_CH) begin
              ch_d    = '0;
              state_d = S_EMIT;
            end else begin
              ch_d = ch_q + 1'b1;
            end
          end
        end else begin
          acc_d = add_res;
          if (ch_q == LAST_CH) begin
            ch_d    = '0;
            state_d = (mode_q == M_REDUCE_PSUM) ? S_FINAL : S_EMIT;
          end else begin
            ch_d = ch_q + 1'b1;
          end
        end
      end

      S_FINAL: begin
        add_b = psum_data;
        if (!psum_empty) begin
          psum_ren = 1'b1;
          acc_d    = add_res;
          state_d  = S_EMIT;
        end
      end

      S_EMIT: begin
        if (!out_full) begin
          out_wen = 1'b1;
          if ((mode_q == M_PASS || mode_q == M_LANE_PSUM) && ch_q != LAST_CH) begin
            ch_d = ch_q + 1'b1;
          end else begin
            ch_d     = '0;
            remain_d = remain_q - 1'b1;
            state_d  = (remain_q == CNT_W'(1)) ? S_DONE : S_CAPTURE;
          end
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    // Abort only redirects the state; strobes already raised this cycle stand.
    if (clear) begin
      state_d = S_IDLE;
    end
  end

  assign pe_ready = (state_q == S_CAPTURE);
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign out_data = (state_q != S_EMIT) ? '0 :
                    (mode_q == M_PASS || mode_q == M_LANE_PSUM) ? lane_sel : acc_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      mode_q   <= M_PASS;
      remain_q <= '0;
      ch_q     <= '0;
      acc_q    <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        lane_q[i] <= '0;
      end
`ifdef PSUM_MERGE_SATURATE_EN
      sat_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      remain_q <= remain_d;
      ch_q     <= ch_d;
      acc_q    <= acc_d;
      lane_q   <= lane_d;
`ifdef PSUM_MERGE_SATURATE_EN
      sat_q    <= sat_d;
`endif
    end
  end

endmodule
